// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for imem_loader.
// master = stream source / memory side, slave = the loader.
interface imem_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport master (
      output in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> big-endian 32-bit words written
// to instruction memory, XOR checksum verified, core held in reset until done.
module imem_loader #(
   parameter int unsigned MAX_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   imem_loader_if.slave  bus,
   output logic          core_rst,
   output logic          done,
   output logic          error,
   output logic [15:0]   words_loaded
);

   typedef enum logic [2:0] {
      LEN_HI,
      LEN_LO,
      DATA,
      CSUM,
      DONE,
      ERROR
   } state_t;

   state_t      state, state_d;
   logic [7:0]  len_hi, len_hi_d;
   logic [15:0] len, len_d;
   logic [23:0] shreg, shreg_d;
   logic [1:0]  idx, idx_d;
   logic [7:0]  acc, acc_d;
   logic [15:0] wl_d;
   logic        wr_en_d;
   logic [31:0] wr_addr_d;
   logic [31:0] wr_data_d;
   logic [15:0] n_full;
   logic        accept;

   always_comb begin
      bus.in_ready = 1'b0;
      if (!rst && !start) begin
         bus.in_ready = (state == LEN_HI) || (state == LEN_LO) ||
                        (state == DATA)   || (state == CSUM);
      end
   end

   assign accept = bus.in_valid && bus.in_ready;
   assign n_full = {len_hi, bus.in_data};

   always_comb begin
      state_d   = state;
      len_hi_d  = len_hi;
      len_d     = len;
      shreg_d   = shreg;
      idx_d     = idx;
      acc_d     = acc;
      wl_d      = words_loaded;
      wr_en_d   = 1'b0;
      wr_addr_d = bus.wr_addr;
      wr_data_d = bus.wr_data;

      if (start) begin
         state_d = LEN_HI;
         wl_d    = '0;
         idx_d   = '0;
         acc_d   = '0;
      end else if (accept) begin
         case (state)
            LEN_HI: begin
               len_hi_d = bus.in_data;
               state_d  = LEN_LO;
            end
            LEN_LO: begin
               len_d = n_full;
               idx_d = '0;
               if (32'(n_full) > MAX_WORDS) begin
                  state_d = ERROR;
               end else if (n_full == '0) begin
                  state_d = CSUM;
               end else begin
                  state_d = DATA;
               end
            end
            DATA: begin
               shreg_d = {shreg[15:0], bus.in_data};
               acc_d   = acc ^ bus.in_data;
               idx_d   = 2'(idx + 2'd1);
               // Fourth byte: register the write so it lands next cycle while
               // the stream keeps flowing; the last word's pulse overlaps CSUM.
               if (idx == 2'd3) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = {shreg, bus.in_data};
                  wr_addr_d = BASE_ADDR + {14'b0, words_loaded, 2'b00};
                  wl_d      = 16'(words_loaded + 16'd1);
                  if (wl_d == len) begin
                     state_d = CSUM;
                  end
               end
            end
            CSUM: begin
               state_d = (bus.in_data == acc) ? DONE : ERROR;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LEN_HI;
         len_hi       <= '0;
         len          <= '0;
         shreg        <= '0;
         idx          <= '0;
         acc          <= '0;
         words_loaded <= '0;
         bus.wr_en    <= 1'b0;
         bus.wr_addr  <= '0;
         bus.wr_data  <= '0;
         core_rst     <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         state        <= state_d;
         len_hi       <= len_hi_d;
         len          <= len_d;
         shreg        <= shreg_d;
         idx          <= idx_d;
         acc          <= acc_d;
         words_loaded <= wl_d;
         bus.wr_en    <= wr_en_d;
         bus.wr_addr  <= wr_addr_d;
         bus.wr_data  <= wr_data_d;
         core_rst     <= (state_d != DONE);
         done         <= (state_d == DONE);
         error        <= (state_d == ERROR);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, abort sequences and
// randomized loads checked against a stream-level reference model.
module tb_imem_loader;
   localparam int unsigned MAXW = 4;
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        core_rst;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   int total = 0;
   int bad = 0;

   logic [7:0]  tx_q[$];
   logic [63:0] wr_q[$];

   imem_loader_if bus();

   imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .bus(bus),
      .core_rst(core_rst),
      .done(done),
      .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (bus.wr_en) wr_q.push_back({bus.wr_addr, bus.wr_data});
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0]  b[12];
      int          len;
      bit          ed;
      bit          ee;
      int          wl;
      int          nw;
      logic [31:0] d0;
      logic [31:0] d1;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_rst();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h5A;
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check("rst_wr_en", 32'(bus.wr_en), 32'd0);
      check("rst_wr_addr", bus.wr_addr, 32'd0);
      check("rst_wr_data", bus.wr_data, 32'd0);
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      #1 check("rst_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = 8'hA5;
      #1 check("start_cycle_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      start = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("start_in_ready", 32'(bus.in_ready), 32'd1);
      check("start_error", 32'(error), 32'd0);
      check("start_done", 32'(done), 32'd0);
      check("start_core_rst", 32'(core_rst), 32'd1);
      check("start_words", 32'(words_loaded), 32'd0);
      wr_q.delete();
   endtask

   // Drives tx_q out with optional idle gaps; returns mid-cycle after the last accept.
   task automatic send(input bit gaps);
      int  cyc;
      bit  acc;
      cyc = 0;
      while (tx_q.size() != 0 && cyc < 500) begin
         @(negedge clk);
         bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.in_data = bus.in_valid ? tx_q[0] : 8'($urandom);
         #1 acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         if (acc) void'(tx_q.pop_front());
         cyc++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("send_drained", 32'(tx_q.size()), 32'd0);
   endtask

   task automatic model(input logic [7:0] s[$], output logic [63:0] ew[$],
                        output bit ed, output bit ee, output int ewl);
      int n;
      logic [7:0] x;
      logic [31:0] w;
      ew = {};
      ed = 1'b0;
      ee = 1'b0;
      ewl = 0;
      n = int'({s[0], s[1]});
      if (n > int'(MAXW)) begin
         ee = 1'b1;
      end else begin
         x = 8'h00;
         for (int i = 0; i < n; i++) begin
            w = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            ew.push_back({BASE + 32'(4 * i), w});
         end
         ewl = n;
         ed = (s[2+4*n] == x);
         ee = !ed;
      end
   endtask

   task automatic compare_load(input string tag, input logic [63:0] ew[$],
                               input bit ed, input bit ee, input int ewl);
      check({tag, "_done_now"}, 32'(done), 32'(ed));
      check({tag, "_error_now"}, 32'(error), 32'(ee));
      repeat (2) @(negedge clk);
      check({tag, "_done"}, 32'(done), 32'(ed));
      check({tag, "_error"}, 32'(error), 32'(ee));
      check({tag, "_core_rst"}, 32'(core_rst), 32'(!ed));
      check({tag, "_words"}, 32'(words_loaded), 32'(ewl));
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(ew.size()));
      for (int i = 0; i < ew.size() && i < wr_q.size(); i++) begin
         check({tag, "_wr_addr"}, wr_q[i][63:32], ew[i][63:32]);
         check({tag, "_wr_data"}, wr_q[i][31:0], ew[i][31:0]);
      end
   endtask

   task automatic load_nominal(input string tag, input bit gaps);
      logic [7:0]  s[$];
      logic [63:0] ew[$];
      bit ed, ee;
      int ewl;
      s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
      model(s, ew, ed, ee, ewl);
      tx_q = s;
      send(gaps);
      compare_load(tag, ew, ed, ee, ewl);
   endtask

   initial begin
      logic [7:0]  s[$];
      logic [63:0] ew[$];
      bit ed, ee;
      int ewl;
      int n;
      logic [7:0] x;

      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;

      vecs[0].b = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00, 8'h00};
      vecs[0].len = 11; vecs[0].ed = 1; vecs[0].ee = 0; vecs[0].wl = 2; vecs[0].nw = 2;
      vecs[0].d0 = 32'h12345678; vecs[0].d1 = 32'h9ABCDEF0;
      vecs[1].b = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01, 8'h00};
      vecs[1].len = 11; vecs[1].ed = 0; vecs[1].ee = 1; vecs[1].wl = 2; vecs[1].nw = 2;
      vecs[1].d0 = 32'h12345678; vecs[1].d1 = 32'h9ABCDEF0;
      vecs[2].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[2].len = 3; vecs[2].ed = 1; vecs[2].ee = 0; vecs[2].wl = 0; vecs[2].nw = 0;
      vecs[2].d0 = '0; vecs[2].d1 = '0;
      vecs[3].b = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[3].len = 2; vecs[3].ed = 0; vecs[3].ee = 1; vecs[3].wl = 0; vecs[3].nw = 0;
      vecs[3].d0 = '0; vecs[3].d1 = '0;

      do_rst();

      for (int v = 0; v < 4; v++) begin
         pulse_start();
         for (int i = 0; i < vecs[v].len; i++) tx_q.push_back(vecs[v].b[i]);
         send(1'b0);
         check("vec_done_now", 32'(done), 32'(vecs[v].ed));
         check("vec_error_now", 32'(error), 32'(vecs[v].ee));
         repeat (2) @(negedge clk);
         check("vec_core_rst", 32'(core_rst), 32'(!vecs[v].ed));
         check("vec_words", 32'(words_loaded), 32'(vecs[v].wl));
         check("vec_in_ready", 32'(bus.in_ready), 32'd0);
         check("vec_nwrites", 32'(wr_q.size()), 32'(vecs[v].nw));
         if (vecs[v].nw == 2 && wr_q.size() == 2) begin
            check("vec_addr0", wr_q[0][63:32], BASE);
            check("vec_data0", wr_q[0][31:0], vecs[v].d0);
            check("vec_addr1", wr_q[1][63:32], BASE + 32'd4);
            check("vec_data1", wr_q[1][31:0], vecs[v].d1);
         end
      end

      // Abort after five data bytes via start: only the first full word lands.
      pulse_start();
      tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
      send(1'b0);
      check("abort_words_before", 32'(words_loaded), 32'd1);
      check("abort_nwrites_before", 32'(wr_q.size()), 32'd1);
      wr_q.delete();
      pulse_start();
      repeat (3) @(negedge clk);
      check("abort_no_partial_write", 32'(wr_q.size()), 32'd0);
      check("abort_core_rst", 32'(core_rst), 32'd1);
      load_nominal("reload_start", 1'b0);

      // Same abort via rst.
      pulse_start();
      tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
      send(1'b0);
      wr_q.delete();
      do_rst();
      repeat (3) @(negedge clk);
      check("rst_abort_no_partial_write", 32'(wr_q.size()), 32'd0);
      load_nominal("reload_rst", 1'b0);

      pulse_start();
      load_nominal("nominal_gaps", 1'b1);

      for (int t = 0; t < 30; t++) begin
         s = {};
         n = $urandom_range(0, MAXW + 2);
         s.push_back(8'(n >> 8));
         s.push_back(8'(n));
         if (n <= int'(MAXW)) begin
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
               s.push_back(8'($urandom));
               x = x ^ s[s.size() - 1];
            end
            s.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
         end
         model(s, ew, ed, ee, ewl);
         pulse_start();
         tx_q = s;
         send(1'b1);
         compare_load("rand", ew, ed, ee, ewl);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
